// File: rtl/upower_ctrl_pkg.sv
// Shared constants for the uPower control pipeline: opcodes, ALU-op codes,
// control-bundle layout and the packed bundle type.
package upower_ctrl_pkg;

  localparam int CW = 11;

  localparam logic [5:0] OP_XFORM = 6'b011111;
  localparam logic [5:0] OP_LD    = 6'b111010;
  localparam logic [5:0] OP_STD   = 6'b111110;
  localparam logic [5:0] OP_BC    = 6'b010011;
  localparam logic [5:0] OP_B     = 6'b010010;
  localparam logic [5:0] OP_ADDI  = 6'b001110;
  localparam logic [5:0] OP_ORI   = 6'b011000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_IMM = 2'b11;

  localparam int OFF_REG_DST    = 10;
  localparam int OFF_ALU_SRC    = 9;
  localparam int OFF_MEM_TO_REG = 8;
  localparam int OFF_REG_WRITE  = 7;
  localparam int OFF_MEM_READ   = 6;
  localparam int OFF_MEM_WRITE  = 5;
  localparam int OFF_BRANCH     = 4;
  localparam int OFF_JUMP       = 3;
  localparam int OFF_SIGN_ZERO  = 2;
  localparam int OFF_ALU_OP     = 0;

  // Field order matches the OFF_* positions above (MSB first).
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       sign_zero;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/upower_ctrl_decode.sv
// Combinational primary-opcode decoder: produces the control bundle and an
// illegal-opcode flag. Unknown opcodes yield an all-zero bundle.
module upower_ctrl_decode
  import upower_ctrl_pkg::*;
(
  input  logic [5:0]    opcode,
  output logic [CW-1:0] ctrl,
  output logic          illegal
);

  ctrl_t w_dec;

  always_comb begin
    w_dec   = '0;
    illegal = 1'b0;
    case (opcode)
      OP_XFORM: begin
        w_dec.reg_dst   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALU_R;
      end
      OP_LD: begin
        w_dec.alu_src    = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.alu_op     = ALU_ADD;
      end
      OP_STD: begin
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
        w_dec.alu_op    = ALU_ADD;
      end
      OP_BC: begin
        w_dec.branch = 1'b1;
        w_dec.alu_op = ALU_BR;
      end
      OP_B: begin
        w_dec.jump = 1'b1;
      end
      OP_ADDI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = ALU_IMM;
      end
      OP_ORI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.sign_zero = 1'b1;
        w_dec.alu_op    = ALU_IMM;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ctrl = w_dec;

endmodule

// File: rtl/upower_ctrl_pipe.sv
// uPower control pipeline: decode in ID, STAGES registered control stages with
// stall/flush/bubble handling. Define UPOWER_CTRL_HAZARD_EN for the load-use
// interlock and the saturating hazard-bubble counter.
module upower_ctrl_pipe
  import upower_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int RW     = 5,
  parameter int CNTW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [5:0]           id_opcode,
  input  logic [RW-1:0]        id_dst,
  input  logic [RW-1:0]        id_src_a,
  input  logic [RW-1:0]        id_src_b,
  input  logic                 stall_in,
  input  logic                 flush_in,
  output logic                 id_ready,
  output logic [STAGES*CW-1:0] stage_ctrl,
  output logic [STAGES-1:0]    stage_valid,
  output logic [STAGES*RW-1:0] stage_dst,
  output logic                 illegal_op,
  output logic [CNTW-1:0]      bubble_cnt
);

  logic [CW-1:0]     w_dec_ctrl;
  logic              w_dec_illegal;
  logic              w_hz;
  logic              w_bubble;

  logic [STAGES-1:0] r_valid;
  logic [CW-1:0]     r_ctrl [STAGES];
  logic [RW-1:0]     r_dst  [STAGES];
  logic              r_illegal;

  upower_ctrl_decode u_decode (
    .opcode  (id_opcode),
    .ctrl    (w_dec_ctrl),
    .illegal (w_dec_illegal)
  );

`ifdef UPOWER_CTRL_HAZARD_EN
  logic [CNTW-1:0] r_bubble_cnt;

  // A load in EX whose destination feeds the ID instruction must wait a cycle.
  assign w_hz = r_valid[0] & r_ctrl[0][OFF_MEM_READ] & id_valid &
                ((r_dst[0] == id_src_a) | (r_dst[0] == id_src_b));

  always_ff @(posedge clk) begin
    if (reset)
      r_bubble_cnt <= '0;
    else if (!stall_in && !flush_in && w_hz && (r_bubble_cnt != '1))
      r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_srcs;

  assign w_unused_srcs = ^{id_src_a, id_src_b};
  assign w_hz          = 1'b0;
  assign bubble_cnt    = '0;
`endif

  assign id_ready = ~stall_in & ~(w_hz & ~flush_in);
  assign w_bubble = flush_in | w_hz;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_ctrl[k] <= '0;
        r_dst[k]  <= '0;
      end
    end else if (!stall_in) begin
      if (w_bubble) begin
        r_valid[0] <= 1'b0;
        r_ctrl[0]  <= '0;
        r_dst[0]   <= '0;
      end else begin
        r_valid[0] <= id_valid;
        r_ctrl[0]  <= w_dec_ctrl;
        r_dst[0]   <= id_dst;
      end
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_ctrl[k]  <= r_ctrl[k-1];
        r_dst[k]   <= r_dst[k-1];
      end
    end
  end

  // Sticky until reset; only an instruction actually taken by ID can set it.
  always_ff @(posedge clk) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (id_ready && id_valid && w_dec_illegal)
      r_illegal <= 1'b1;
  end

  assign illegal_op  = r_illegal;
  assign stage_valid = r_valid;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_out
    assign stage_ctrl[gi*CW +: CW] = r_ctrl[gi];
    assign stage_dst[gi*RW +: RW]  = r_dst[gi];
  end

endmodule

// File: tb/tb_upower_ctrl_pipe.sv
// Self-checking bench for upower_ctrl_pipe (STAGES=3, CNTW=4). A scoreboard
// queue holds expected {bundle, dst} for every accepted instruction; it is
// popped when that instruction leaves the last stage.
module tb_upower_ctrl_pipe;

  localparam int STAGES = 3;
  localparam int RW     = 5;
  localparam int CNTW   = 4;

  localparam logic [5:0] XF   = 6'b011111;
  localparam logic [5:0] LD   = 6'b111010;
  localparam logic [5:0] STD  = 6'b111110;
  localparam logic [5:0] BC   = 6'b010011;
  localparam logic [5:0] BR   = 6'b010010;
  localparam logic [5:0] ADDI = 6'b001110;
  localparam logic [5:0] ORI  = 6'b011000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 id_valid;
  logic [5:0]           id_opcode;
  logic [RW-1:0]        id_dst, id_src_a, id_src_b;
  logic                 stall_in, flush_in;
  logic                 id_ready;
  logic [STAGES*11-1:0] stage_ctrl;
  logic [STAGES-1:0]    stage_valid;
  logic [STAGES*RW-1:0] stage_dst;
  logic                 illegal_op;
  logic [CNTW-1:0]      bubble_cnt;

  int          vectors    = 0;
  int          miscompares = 0;
  int          exp_bub    = 0;
  logic [15:0] sb_q[$];
  logic        sb_push    = 1'b0;
  logic        adv        = 1'b0;

  upower_ctrl_pipe #(.STAGES(STAGES), .RW(RW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_dst      (id_dst),
    .id_src_a    (id_src_a),
    .id_src_b    (id_src_b),
    .stall_in    (stall_in),
    .flush_in    (flush_in),
    .id_ready    (id_ready),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .stage_dst   (stage_dst),
    .illegal_op  (illegal_op),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode: {reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, branch, jump, sign_zero, alu_op[1:0]}.
  function automatic logic [10:0] ref_dec(input logic [5:0] op);
    case (op)
      XF:      return 11'b100_1000_0010;
      LD:      return 11'b011_1100_0000;
      STD:     return 11'b010_0010_0000;
      BC:      return 11'b000_0001_0001;
      BR:      return 11'b000_0000_1000;
      ADDI:    return 11'b010_1000_0011;
      ORI:     return 11'b010_1000_0111;
      default: return 11'b000_0000_0000;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] dst,
                       input logic [4:0] sa, input logic [4:0] sb,
                       input logic stl, input logic fl, input logic push);
    id_valid  = v;
    id_opcode = op;
    id_dst    = dst;
    id_src_a  = sa;
    id_src_b  = sb;
    stall_in  = stl;
    flush_in  = fl;
    sb_push   = push;
  endtask

  task automatic idle_in();
    drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard producer: record what each accepted instruction must look like.
  always @(posedge clk) begin
    adv <= !reset && !stall_in;
    if (reset)
      sb_q.delete();
    else if (sb_push && !stall_in)
      sb_q.push_back({ref_dec(id_opcode), id_dst});
  end

  // Scoreboard consumer: last stage after every advancing edge.
  always @(negedge clk) begin
    if (adv && stage_valid[STAGES-1]) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: last stage valid ctrl=%b dst=%0d, nothing expected",
                 stage_ctrl[32:22], stage_dst[14:10]);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        $display("retire ctrl=%b dst=%0d", stage_ctrl[32:22], stage_dst[14:10]);
        if ({stage_ctrl[32:22], stage_dst[14:10]} !== e) begin
          miscompares++;
          $display("FAIL sb_retire: got ctrl=%b dst=%0d, want ctrl=%b dst=%0d",
                   stage_ctrl[32:22], stage_dst[14:10], e[15:5], e[4:0]);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    vectors++;
    if ({stage_valid, stage_ctrl, stage_dst, illegal_op, bubble_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b ctrl=%h dst=%h ill=%b cnt=%0d, want all 0",
               stage_valid, stage_ctrl, stage_dst, illegal_op, bubble_cnt);
    end
    reset = 1'b0;
    drive(1'b1, LD, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++; $display("FAIL ld_ready: got %b want 1", id_ready);
    end
    @(negedge clk);
    $display("ld after 1 cycle: ctrl0=%b valid=%b", stage_ctrl[10:0], stage_valid);
    vectors++;
    if (stage_ctrl[10:0] !== 11'b01111000000 || stage_valid !== 3'b001 || stage_dst[4:0] !== 5'd3) begin
      miscompares++;
      $display("FAIL ld_ex: got ctrl=%b valid=%b dst=%0d want 01111000000 001 3",
               stage_ctrl[10:0], stage_valid, stage_dst[4:0]);
    end
    idle_in();
    repeat (2) @(negedge clk);
    vectors++;
    if (stage_valid !== 3'b100) begin
      miscompares++; $display("FAIL ld_last: valid got %b want 100", stage_valid);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, LD, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
`ifdef UPOWER_CTRL_HAZARD_EN
    drive(1'b1, XF, 5'd7, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (id_ready !== 1'b0) begin
      miscompares++; $display("FAIL lu_stall_ready: got %b want 0", id_ready);
    end
    exp_bub = sat_inc(exp_bub);
    @(negedge clk);
    vectors++;
    if (stage_valid[1:0] !== 2'b10 || stage_ctrl[10:0] !== 11'd0 || bubble_cnt !== CNTW'(exp_bub)) begin
      miscompares++;
      $display("FAIL lu_bubble: valid=%b ctrl0=%b cnt=%0d want x10 0 %0d",
               stage_valid, stage_ctrl[10:0], bubble_cnt, exp_bub);
    end
`endif
    drive(1'b1, XF, 5'd7, 5'd5, 5'd1, 1'b0, 1'b0, 1'b1);
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++; $display("FAIL lu_accept_ready: got %b want 1", id_ready);
    end
    @(negedge clk);
    vectors++;
    if (stage_ctrl[10:0] !== 11'b10010000010 || stage_valid[0] !== 1'b1 || stage_dst[4:0] !== 5'd7
        || bubble_cnt !== CNTW'(exp_bub)) begin
      miscompares++;
      $display("FAIL lu_xform_ex: ctrl=%b v0=%b dst=%0d cnt=%0d want 10010000010 1 7 %0d",
               stage_ctrl[10:0], stage_valid[0], stage_dst[4:0], bubble_cnt, exp_bub);
    end
    idle_in();
  endtask

  task automatic test_flush();
    drive(1'b1, ADDI, 5'd8, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_ready: got %b want 1", id_ready);
    end
    @(negedge clk);
    vectors++;
    if (stage_valid[0] !== 1'b0 || stage_ctrl[10:0] !== 11'd0 || bubble_cnt !== CNTW'(exp_bub)) begin
      miscompares++;
      $display("FAIL flush_bubble: v0=%b ctrl0=%b cnt=%0d want 0 0 %0d",
               stage_valid[0], stage_ctrl[10:0], bubble_cnt, exp_bub);
    end
    idle_in();
  endtask

  task automatic test_stall_priority();
    logic [32:0] e_ctrl;
    e_ctrl = '0;
    e_ctrl[10:0] = ref_dec(LD);
    repeat (3) @(negedge clk);
    drive(1'b1, LD, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b1, XF, 5'd11, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    #1;
    vectors++;
    if (id_ready !== 1'b0) begin
      miscompares++; $display("FAIL stall_ready: got %b want 0", id_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (stage_valid !== 3'b001 || stage_ctrl !== e_ctrl || stage_dst !== 15'd9
          || bubble_cnt !== CNTW'(exp_bub)) begin
        miscompares++;
        $display("FAIL stall_hold%0d: valid=%b ctrl=%h dst=%h cnt=%0d want 001 %h 9 %0d",
                 i, stage_valid, stage_ctrl, stage_dst, bubble_cnt, e_ctrl, exp_bub);
      end
    end
`ifdef UPOWER_CTRL_HAZARD_EN
    drive(1'b1, XF, 5'd11, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0);
    exp_bub = sat_inc(exp_bub);
    @(negedge clk);
`endif
    drive(1'b1, XF, 5'd11, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vectors++;
    if (stage_ctrl[10:0] !== ref_dec(XF) || bubble_cnt !== CNTW'(exp_bub)) begin
      miscompares++;
      $display("FAIL stall_release: ctrl0=%b cnt=%0d want %b %0d",
               stage_ctrl[10:0], bubble_cnt, ref_dec(XF), exp_bub);
    end
    idle_in();
  endtask

  task automatic test_illegal();
    vectors++;
    if (illegal_op !== 1'b0) begin
      miscompares++; $display("FAIL illegal_pre: got %b want 0", illegal_op);
    end
    drive(1'b1, 6'b000001, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    vectors++;
    if (illegal_op !== 1'b1 || stage_valid[0] !== 1'b1 || stage_ctrl[10:0] !== 11'd0) begin
      miscompares++;
      $display("FAIL illegal_set: ill=%b v0=%b ctrl0=%b want 1 1 0",
               illegal_op, stage_valid[0], stage_ctrl[10:0]);
    end
    idle_in();
    repeat (3) @(negedge clk);
    vectors++;
    if (illegal_op !== 1'b1) begin
      miscompares++; $display("FAIL illegal_sticky: got %b want 1", illegal_op);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [7];
    ops = '{XF, LD, STD, BC, BR, ADDI, ORI};
    for (int i = 0; i < 7; i++) begin
      if (i % 3 == 2) begin
        drive(1'b1, ops[i], 5'(10 + i), 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        vectors++;
        if (id_ready !== 1'b0) begin
          miscompares++; $display("FAIL b2b_stall_ready%0d: got %b want 0", i, id_ready);
        end
        @(negedge clk);
      end
      drive(1'b1, ops[i], 5'(10 + i), 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
      #1;
      vectors++;
      if (id_ready !== 1'b1) begin
        miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", i, id_ready);
      end
      @(negedge clk);
    end
    idle_in();
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 20; p++) begin
      drive(1'b1, LD, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
`ifdef UPOWER_CTRL_HAZARD_EN
      drive(1'b1, ORI, 5'd12, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
      exp_bub = sat_inc(exp_bub);
      @(negedge clk);
`endif
      drive(1'b1, ORI, 5'd12, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    idle_in();
    vectors++;
    if (bubble_cnt !== CNTW'(exp_bub)) begin
      miscompares++; $display("FAIL saturation: cnt=%0d want %0d", bubble_cnt, exp_bub);
    end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, ADDI, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stage_valid, stage_ctrl, stage_dst, illegal_op, bubble_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_midop: valid=%b ctrl=%h dst=%h ill=%b cnt=%0d want all 0",
               stage_valid, stage_ctrl, stage_dst, illegal_op, bubble_cnt);
    end
    reset = 1'b0;
    exp_bub = 0;
    drive(1'b1, ADDI, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle_in();
    repeat (4) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++; $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_load_use();
    test_flush();
    test_stall_priority();
    test_illegal();
    test_back_to_back();
    test_saturation();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
